// File: rtl/scansione_pkg.sv
// Shared types and default 1280x1024 timing for the raster generator.
package scansione_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        ATTIVO,
        FRONT,
        SYNC,
        BACK
    } fase_e;

    localparam int COORD_MAX    = 2048;

    localparam int H_ATTIVO_DEF = 1280;
    localparam int H_FRONT_DEF  = 48;
    localparam int H_SYNC_DEF   = 112;
    localparam int H_BACK_DEF   = 248;

    localparam int V_ATTIVO_DEF = 1024;
    localparam int V_FRONT_DEF  = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BACK_DEF   = 38;

endpackage

// File: rtl/scansione_vga_if.sv
// Raster output bundle: pixel enable in, coordinates and sync out.
interface scansione_vga_if;
    import scansione_pkg::*;

    logic   ABILITA;
    coord_t X_CONTROLLO;
    coord_t Y_CONTROLLO;
    logic   VISIBILE;
    logic   HSYNC;
    logic   VSYNC;
    logic   INIZIO_RIGA;
    logic   INIZIO_QUADRO;

    modport master (
        input  ABILITA,
        output X_CONTROLLO, Y_CONTROLLO, VISIBILE,
        output HSYNC, VSYNC, INIZIO_RIGA, INIZIO_QUADRO
    );

    modport slave (
        output ABILITA,
        input  X_CONTROLLO, Y_CONTROLLO, VISIBILE,
        input  HSYNC, VSYNC, INIZIO_RIGA, INIZIO_QUADRO
    );

endinterface

// File: rtl/scansione_vga_contatore_fase.sv
// One raster axis: wrapping counter plus its ATTIVO/FRONT/SYNC/BACK phase.
module contatore_fase
    import scansione_pkg::*;
#(
    parameter int L_ATT = H_ATTIVO_DEF,
    parameter int L_FR  = H_FRONT_DEF,
    parameter int L_SY  = H_SYNC_DEF,
    parameter int L_BK  = H_BACK_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t cnt,
    output fase_e  fase,
    output logic   wrap
);

    localparam int TOT = L_ATT + L_FR + L_SY + L_BK;

    localparam coord_t FINE_ATT = coord_t'(L_ATT - 1);
    localparam coord_t FINE_FR  = coord_t'(L_ATT + L_FR - 1);
    localparam coord_t FINE_SY  = coord_t'(L_ATT + L_FR + L_SY - 1);
    localparam coord_t FINE_BK  = coord_t'(TOT - 1);

    coord_t cnt_q, cnt_d;
    fase_e  fase_q, fase_d;

    always_comb begin
        wrap   = en && (cnt_q == FINE_BK);
        cnt_d  = cnt_q;
        fase_d = fase_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 11'd1;
            unique case (fase_q)
                ATTIVO: if (cnt_q == FINE_ATT) fase_d = FRONT;
                FRONT:  if (cnt_q == FINE_FR)  fase_d = SYNC;
                SYNC:   if (cnt_q == FINE_SY)  fase_d = BACK;
                BACK:   if (cnt_q == FINE_BK)  fase_d = ATTIVO;
                default: fase_d = ATTIVO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fase_q <= ATTIVO;
        end else begin
            cnt_q  <= cnt_d;
            fase_q <= fase_d;
        end
    end

    assign cnt  = cnt_q;
    assign fase = fase_q;

endmodule

// File: rtl/scansione_vga.sv
// Raster timing generator: scan coordinates, syncs, visible flag, strobes.
module scansione_vga
    import scansione_pkg::*;
#(
    parameter int H_ATTIVO = H_ATTIVO_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ATTIVO = V_ATTIVO_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic   CLK,
    input  logic   RST_N,
    input  logic   ABILITA,
    output coord_t X_CONTROLLO,
    output coord_t Y_CONTROLLO,
    output logic   VISIBILE,
    output logic   HSYNC,
    output logic   VSYNC,
    output logic   INIZIO_RIGA,
    output logic   INIZIO_QUADRO
);

    localparam int H_TOT = H_ATTIVO + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ATTIVO + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOT > COORD_MAX || V_TOT > COORD_MAX) begin : g_chk
            $error("scansione_vga: H_TOT/V_TOT exceed 11-bit range");
        end
    endgenerate

    coord_t hc, vc;
    fase_e  hf, vf;
    logic   h_wrap;
    logic   v_wrap_unused;

    contatore_fase #(
        .L_ATT(H_ATTIVO), .L_FR(H_FRONT), .L_SY(H_SYNC), .L_BK(H_BACK)
    ) u_h (
        .clk(CLK), .rst_n(RST_N), .en(ABILITA),
        .cnt(hc), .fase(hf), .wrap(h_wrap)
    );

    // h_wrap is already qualified by ABILITA
    contatore_fase #(
        .L_ATT(V_ATTIVO), .L_FR(V_FRONT), .L_SY(V_SYNC), .L_BK(V_BACK)
    ) u_v (
        .clk(CLK), .rst_n(RST_N), .en(h_wrap),
        .cnt(vc), .fase(vf), .wrap(v_wrap_unused)
    );

    coord_t x_q, x_d, y_q, y_d;
    logic   vis_q, vis_d, hs_q, hs_d, vs_q, vs_d;
    logic   riga_q, riga_d, quadro_q, quadro_d;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vis_d    = vis_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        riga_d   = 1'b0;
        quadro_d = 1'b0;
        if (ABILITA) begin
            x_d      = hc;
            y_d      = vc;
            vis_d    = (hf == ATTIVO) && (vf == ATTIVO);
            hs_d     = (hf == SYNC) ? HS_POL : ~HS_POL;
            vs_d     = (vf == SYNC) ? VS_POL : ~VS_POL;
            riga_d   = (hc == '0);
            quadro_d = (hc == '0) && (vc == '0);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q      <= '0;
            y_q      <= '0;
            vis_q    <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            riga_q   <= 1'b0;
            quadro_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vis_q    <= vis_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            riga_q   <= riga_d;
            quadro_q <= quadro_d;
        end
    end

    assign X_CONTROLLO   = x_q;
    assign Y_CONTROLLO   = y_q;
    assign VISIBILE      = vis_q;
    assign HSYNC         = hs_q;
    assign VSYNC         = vs_q;
    assign INIZIO_RIGA   = riga_q;
    assign INIZIO_QUADRO = quadro_q;

endmodule

// File: doc/scansione_vga.md
# scansione_vga

Raster timing generator for the 1280×1024 display path. It produces the scan coordinates X_CONTROLLO/Y_CONTROLLO that every shape hit-test block in the design consumes, plus the horizontal and vertical sync pulses, the visible-area flag, and line/frame start strobes. It sits between the pixel clock domain and the shape/colour mux, and is the single source of raster position in the design.

## Interface
Parameters:
- H_ATTIVO, 1280: visible pixels per line
- H_FRONT, 48: horizontal front porch, in pixels
- H_SYNC, 112: horizontal sync width, in pixels
- H_BACK, 248: horizontal back porch, in pixels
- V_ATTIVO, 1024: visible lines per frame
- V_FRONT, 1: vertical front porch, in lines
- V_SYNC, 3: vertical sync width, in lines
- V_BACK, 38: vertical back porch, in lines
- HS_POL, 1: active level of HSYNC
- VS_POL, 1: active level of VSYNC

Ports:
- CLK  in  1  pixel clock; one clock domain only
- RST_N  in  1  reset, asynchronous, active-low
- ABILITA  in  1  pixel enable; the block advances only on cycles where this is high
- X_CONTROLLO  out  11  horizontal counter, 0 .. H_TOT-1
- Y_CONTROLLO  out  11  vertical counter, 0 .. V_TOT-1
- VISIBILE  out  1  high when X < H_ATTIVO and Y < V_ATTIVO
- HSYNC  out  1  horizontal sync, active level HS_POL
- VSYNC  out  1  vertical sync, active level VS_POL
- INIZIO_RIGA  out  1  one-cycle strobe when X = 0
- INIZIO_QUADRO  out  1  one-cycle strobe when X = 0 and Y = 0

## Operation
- Derived totals:
  - H_TOT = sum of the four H parameters (1688 by default)
  - V_TOT = sum of the four V parameters (1066 by default)
  - Both totals must be ≤ 2048. An elaboration-time check fails the build otherwise.
- Internal counters hc and vc, each 11 bits:
  - On an enabled cycle, hc increments. It wraps from H_TOT-1 to 0.
  - vc increments only on the cycle hc wraps. It wraps from V_TOT-1 to 0.
  - No other wrap point exists.
- Each axis has a phase FSM with states ATTIVO → FRONT → SYNC → BACK → ATTIVO.
  - A transition happens on the enabled cycle where the axis counter reaches the last value of the current phase.
  - Horizontal phase boundaries at default parameters:
    - ATTIVO 0–1279
    - FRONT 1280–1327
    - SYNC 1328–1439
    - BACK 1440–1687
  - Vertical phase boundaries at default parameters:
    - ATTIVO 0–1023
    - FRONT 1024
    - SYNC 1025–1027
    - BACK 1028–1065
  - The vertical FSM advances only on horizontal wrap.
- Output derivation:
  - HSYNC = HS_POL when the horizontal phase is SYNC, otherwise !HS_POL. VSYNC is derived the same way from the vertical phase.
  - VISIBILE = both phases in ATTIVO.
- When ABILITA is low, counters, phases and all outputs hold, except the strobes.
  - INIZIO_RIGA and INIZIO_QUADRO are forced to 0 on every disabled cycle.
  - A strobe therefore lasts exactly one enabled cycle.
- Reset (asynchronous, RST_N = 0):
  - hc = 0, vc = 0, both phases = ATTIVO
  - X_CONTROLLO = 0, Y_CONTROLLO = 0
  - VISIBILE = 0
  - HSYNC = !HS_POL, VSYNC = !VS_POL
  - INIZIO_RIGA = 0, INIZIO_QUADRO = 0
- Reset asserted mid-frame aborts the frame immediately, with no end-of-frame cleanup.

## Timing
- Every output is a register.
- All outputs describe the same pixel (hc, vc) and appear one enabled cycle after the counter holds that value. Latency is 1 enabled cycle, and no output is skewed against another.
- First enabled cycle after RST_N deasserts:
  - X_CONTROLLO = 0, Y_CONTROLLO = 0
  - VISIBILE = 1
  - INIZIO_RIGA = 1, INIZIO_QUADRO = 1
  - HSYNC and VSYNC inactive
- End of line: the last line pixel (X = H_TOT-1) is followed by X = 0 with Y+1 on the next enabled cycle.
- End of frame: X = H_TOT-1, Y = V_TOT-1 is followed by X = 0, Y = 0, with INIZIO_QUADRO = 1.
- Downstream hit-test logic sees the coordinates combinationally. The colour mux must register together with HSYNC/VSYNC to stay aligned.

## Structure
- Package scansione_pkg holds:
  - the phase enum (ATTIVO, FRONT, SYNC, BACK)
  - the 11-bit coordinate type
  - the default 1280×1024 timing constants
- Sub-module contatore_fase: one counter plus one phase FSM, parameterised by the four phase lengths.
  - Inputs: an advance enable and CLK/RST_N.
  - Outputs: count, phase, and a wrap flag.
  - Instantiated twice. The horizontal instance is enabled by ABILITA; the vertical instance is enabled by ABILITA && horizontal wrap.
- Top level: output registers, sync-polarity mapping, and strobe generation.

## Test plan
- Reset and first pixel:
  - Hold RST_N = 0 with ABILITA = 1 → all outputs at their reset values, HSYNC = VSYNC = 0.
  - Release reset → after 1 cycle: X = 0, Y = 0, VISIBILE = 1, both strobes = 1. After 2 cycles both strobes = 0.
- Horizontal sweep with ABILITA held high:
  - HSYNC is high exactly for X = 1328..1439 (112 cycles).
  - VISIBILE drops at X = 1280.
  - After X = 1687, the next output is X = 0, Y = 1, INIZIO_RIGA = 1, INIZIO_QUADRO = 0.
- Full frame:
  - VSYNC is high for Y = 1025..1027.
  - VISIBILE = 0 for all of Y = 1024..1065.
  - X = 1687, Y = 1065 is followed by X = 0, Y = 0, INIZIO_QUADRO = 1.
  - Frame period = 1688 × 1066 = 1 799 408 enabled cycles.
- Enable stall:
  - Toggle ABILITA in a 1-on/2-off pattern → coordinates advance once per enabled cycle only.
  - Strobes are never high on a disabled cycle.
  - Frame length measured in enabled cycles is unchanged.
- Reset mid-frame: assert RST_N = 0 asynchronously at X = 500, Y = 700 → outputs go to reset values without waiting for a clock edge; after release, the frame restarts from X = 0, Y = 0.
- Parameter override:
  - With H = 8/2/2/4 and V = 4/1/1/2 → H_TOT = 16, V_TOT = 8; HSYNC is active for X = 10..11 and VSYNC for Y = 5.
  - With HS_POL = 0 → HSYNC idles at 1.
